// File: rtl/umi_mem_responder.sv
// UMI memory responder: BRAM-backed line array answering MemReq beats.
// Reads travel a fixed-latency pipeline into a response FIFO; credit-based
// admission bounds outstanding reads to the FIFO depth so backpressure can
// never overflow it.

package umi_mem_pkg;
  localparam int unsigned UMI_DATA_WIDTH = 576;

  typedef struct packed {
    logic                      valid;
    logic                      is_write;
    logic [63:0]               addr;
    logic [UMI_DATA_WIDTH-1:0] data;
  } mem_req_t;

  typedef struct packed {
    logic                      valid;
    logic [UMI_DATA_WIDTH-1:0] data;
  } mem_resp_t;
endpackage

module umi_mem_responder
  import umi_mem_pkg::*;
#(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned LINE_LSB     = 6,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned RESP_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  mem_req_t    mem_req,
  output logic        mem_req_grant,
  output mem_resp_t   mem_resp,
  input  logic        mem_resp_grant,
  output logic        oob_error,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = $clog2(RESP_DEPTH);
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
  localparam logic [CNT_W-1:0] RESP_DEPTH_C = CNT_W'(RESP_DEPTH);

  typedef logic [UMI_DATA_WIDTH-1:0] line_t;

  line_t                   mem         [DEPTH];
  line_t                   pipe_data_q [READ_LATENCY];
  line_t                   fifo_mem    [RESP_DEPTH];
  logic [READ_LATENCY-1:0] pipe_vld_q;
  logic [READ_LATENCY-1:0] pipe_oob_q;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        fifo_cnt_q;
  // Reads in the pipeline plus entries in the FIFO.
  logic [CNT_W-1:0]        outst_q;
  logic                    active_q;
  logic                    oob_q;
  logic [31:0]             rd_count_q, wr_count_q;

  logic [IDX_W-1:0] line_idx;
  logic             in_range;
  logic             fifo_empty, push, pop;
  logic             accept, acc_rd, acc_wr;
  line_t            push_data;

  assign line_idx   = mem_req.addr[LINE_LSB +: IDX_W];
  assign in_range   = (mem_req.addr >> (LINE_LSB + IDX_W)) == 64'd0;
  assign fifo_empty = (fifo_cnt_q == '0);
  assign pop        = !fifo_empty && mem_resp_grant;
  assign push       = pipe_vld_q[READ_LATENCY-1];
  assign push_data  = pipe_oob_q[READ_LATENCY-1] ? '0 : pipe_data_q[READ_LATENCY-1];

  // Grant depends only on registered credit state and the pop, never on mem_req.
  assign mem_req_grant = active_q &&
                         ((outst_q < RESP_DEPTH_C) || ((outst_q == RESP_DEPTH_C) && pop));
  assign accept = mem_req.valid && mem_req_grant;
  assign acc_rd = accept && !mem_req.is_write;
  assign acc_wr = accept && mem_req.is_write;

  assign oob_error = oob_q;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;

  // Line array write, registered read and data pipeline/FIFO storage (not reset).
  always_ff @(posedge clk) begin
    if (acc_wr && in_range) mem[line_idx] <= mem_req.data;
    pipe_data_q[0] <= mem[line_idx];
    for (int i = 1; i < int'(READ_LATENCY); i++) pipe_data_q[i] <= pipe_data_q[i-1];
    if (push) fifo_mem[wr_ptr_q] <= push_data;
  end

  // Read pipeline occupancy and out-of-range tags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe_vld_q <= '0;
      pipe_oob_q <= '0;
    end else begin
      pipe_vld_q[0] <= acc_rd;
      pipe_oob_q[0] <= !in_range;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_oob_q[i] <= pipe_oob_q[i-1];
      end
    end
  end

  // FIFO pointers, occupancy and admission credits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      outst_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fifo_cnt_q <= fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
      outst_q    <= outst_q + CNT_W'(acc_rd) - CNT_W'(pop);
    end
  end

  // Status: counters, sticky out-of-range flag, post-reset enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_q   <= 1'b0;
      oob_q      <= 1'b0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      active_q <= 1'b1;
      if (acc_rd) rd_count_q <= rd_count_q + 32'd1;
      if (acc_wr) wr_count_q <= wr_count_q + 32'd1;
      if (accept && !in_range) oob_q <= 1'b1;
    end
  end

  // Response beat straight from the FIFO head; zero data while empty.
  always_comb begin
    mem_resp       = '0;
    mem_resp.valid = !fifo_empty;
    if (!fifo_empty) mem_resp.data = fifo_mem[rd_ptr_q];
  end

endmodule

// File: tb/tb_umi_mem_responder.sv
// Bench for umi_mem_responder: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.

module tb_umi_mem_responder;
  import umi_mem_pkg::*;

  localparam int unsigned DEPTH        = 1024;
  localparam int unsigned LINE_LSB     = 6;
  localparam int unsigned READ_LATENCY = 2;
  localparam int unsigned RESP_DEPTH   = 8;
  localparam int unsigned IDX_W        = $clog2(DEPTH);

  typedef logic [UMI_DATA_WIDTH-1:0] line_t;
  typedef struct {
    line_t data;
    int    ready;
  } pend_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  mem_req_t    mem_req;
  logic        mem_req_grant;
  mem_resp_t   mem_resp;
  logic        mem_resp_grant;
  logic        oob_error;
  logic [31:0] rd_count, wr_count;

  int total = 0;
  int bad   = 0;

  umi_mem_responder #(
    .DEPTH        (DEPTH),
    .LINE_LSB     (LINE_LSB),
    .READ_LATENCY (READ_LATENCY),
    .RESP_DEPTH   (RESP_DEPTH)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .mem_req        (mem_req),
    .mem_req_grant  (mem_req_grant),
    .mem_resp       (mem_resp),
    .mem_resp_grant (mem_resp_grant),
    .oob_error      (oob_error),
    .rd_count       (rd_count),
    .wr_count       (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input line_t got, input line_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  // Reference model state
  line_t model_mem [DEPTH];
  pend_t mq[$];
  int    outst, m_rd, m_wr;
  logic  m_oob;
  int    cyc = 0;
  int    since_rst = 0;

  // Logs of DUT-side events for directed checks
  line_t resp_q[$];
  int    resp_cyc_q[$];
  int    acc_cyc_q[$];

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    since_rst <= rstn ? since_rst + 1 : 0;
  end

  // Every cycle: compare DUT against the model, then advance the model.
  always @(negedge clk) begin : cmp
    logic  exp_valid, exp_pop, exp_grant, inr;
    int    idx;
    pend_t p;
    if (!rstn) begin
      mq.delete();
      outst = 0; m_rd = 0; m_wr = 0; m_oob = 1'b0;
      chk("rst_valid", line_t'(mem_resp.valid), '0);
      chk("rst_data", mem_resp.data, '0);
      chk("rst_grant", line_t'(mem_req_grant), '0);
      chk("rst_rd_count", line_t'(rd_count), '0);
      chk("rst_wr_count", line_t'(wr_count), '0);
      chk("rst_oob", line_t'(oob_error), '0);
    end else begin
      exp_valid = (mq.size() > 0) && (mq[0].ready <= cyc);
      exp_pop   = exp_valid && mem_resp_grant;
      exp_grant = (since_rst > 0) &&
                  ((outst < int'(RESP_DEPTH)) || ((outst == int'(RESP_DEPTH)) && exp_pop));
      chk("resp_valid", line_t'(mem_resp.valid), line_t'(exp_valid));
      if (exp_valid) chk("resp_data", mem_resp.data, mq[0].data);
      if (since_rst > 0) chk("req_grant", line_t'(mem_req_grant), line_t'(exp_grant));
      chk("rd_count", line_t'(rd_count), line_t'(32'(m_rd)));
      chk("wr_count", line_t'(wr_count), line_t'(32'(m_wr)));
      chk("oob_error", line_t'(oob_error), line_t'(m_oob));

      if (mem_resp.valid && mem_resp_grant) begin
        resp_q.push_back(mem_resp.data);
        resp_cyc_q.push_back(cyc);
      end
      if (mem_req.valid && mem_req_grant && !mem_req.is_write) acc_cyc_q.push_back(cyc);

      if (exp_pop) begin
        void'(mq.pop_front());
        outst--;
      end
      if (mem_req.valid && exp_grant) begin
        inr = (mem_req.addr >> LINE_LSB) < 64'(DEPTH);
        idx = int'(mem_req.addr[LINE_LSB +: IDX_W]);
        if (!inr) m_oob = 1'b1;
        if (mem_req.is_write) begin
          m_wr++;
          if (inr) model_mem[idx] = mem_req.data;
        end else begin
          m_rd++;
          outst++;
          p.data  = inr ? model_mem[idx] : '0;
          p.ready = cyc + int'(READ_LATENCY) + 1;
          mq.push_back(p);
        end
      end
    end
  end

  logic rand_en = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_en) mem_resp_grant = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic w, input logic [63:0] a, input line_t d);
    int   n;
    logic got;
    n = 0;
    got = 1'b0;
    mem_req.valid    = 1'b1;
    mem_req.is_write = w;
    mem_req.addr     = a;
    mem_req.data     = d;
    while (!got && n < 200) begin
      @(negedge clk);
      got = mem_req_grant;
      tick();
      n++;
    end
    mem_req.valid = 1'b0;
    if (!got) chk("send_timeout", line_t'(got), line_t'(1));
  endtask

  task automatic wait_resp(input string name, input int n, input int limit);
    int k;
    k = 0;
    while (resp_q.size() < n && k < limit) begin
      tick();
      k++;
    end
    chk(name, line_t'(resp_q.size()), line_t'(n));
  endtask

  function automatic line_t rnd_line();
    line_t r;
    for (int i = 0; i < int'(UMI_DATA_WIDTH / 32); i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    n, k, cnt, w, r;
    line_t shadow [16];
    logic  written [16];
    line_t exp_q[$];

    mem_req        = '0;
    mem_resp_grant = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) tick();

    // Ordered reads of freshly written lines
    mem_resp_grant = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b1, 64'(i) << 6, line_t'(8'hA0 + i));
    resp_q.delete(); resp_cyc_q.delete(); acc_cyc_q.delete();
    send(1'b0, 64'h0C0, '0);
    send(1'b0, 64'h000, '0);
    send(1'b0, 64'h080, '0);
    send(1'b0, 64'h040, '0);
    wait_resp("t1_resp_cnt", 4, 50);
    if (resp_q.size() >= 4) begin
      chk("t1_resp0", resp_q[0], line_t'(8'hA3));
      chk("t1_resp1", resp_q[1], line_t'(8'hA0));
      chk("t1_resp2", resp_q[2], line_t'(8'hA2));
      chk("t1_resp3", resp_q[3], line_t'(8'hA1));
      chk("t1_latency", line_t'(resp_cyc_q[0] - acc_cyc_q[0]), line_t'(3));
    end
    chk("t1_wr_count", line_t'(wr_count), line_t'(4));
    chk("t1_rd_count", line_t'(rd_count), line_t'(4));

    // Credit limit under full backpressure, then resume on pop
    repeat (5) tick();
    resp_q.delete();
    mem_resp_grant   = 1'b0;
    mem_req.valid    = 1'b1;
    mem_req.is_write = 1'b0;
    mem_req.addr     = 64'h0;
    mem_req.data     = '0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req_grant) n++;
      tick();
    end
    chk("t2_accepted_bp", line_t'(n), line_t'(8));
    mem_resp_grant = 1'b1;
    @(negedge clk);
    chk("t2_resume_grant", line_t'(mem_req_grant), line_t'(1));
    if (mem_req_grant) n++;
    tick();
    k = 0;
    while (n < 20 && k < 100) begin
      @(negedge clk);
      if (mem_req_grant) n++;
      tick();
      k++;
    end
    mem_req.valid = 1'b0;
    chk("t2_accepted_all", line_t'(n), line_t'(20));
    wait_resp("t2_resp_cnt", 20, 100);
    if (resp_q.size() >= 20) chk("t2_last_data", resp_q[19], line_t'(8'hA0));

    // Read-after-write in consecutive cycles
    resp_q.delete();
    send(1'b1, 64'h40, line_t'(64'h1234_5678_9ABC_DEF0));
    send(1'b0, 64'h40, '0);
    wait_resp("t3_resp_cnt", 1, 50);
    if (resp_q.size() >= 1) chk("t3_raw_data", resp_q[0], line_t'(64'h1234_5678_9ABC_DEF0));

    // Out-of-range read and write
    resp_q.delete();
    send(1'b0, 64'h10000, '0);
    wait_resp("t4_resp_cnt", 1, 50);
    if (resp_q.size() >= 1) chk("t4_oob_data", resp_q[0], '0);
    chk("t4_oob_set", line_t'(oob_error), line_t'(1));
    send(1'b1, 64'd1 << 40, line_t'(16'hDEAD));
    send(1'b0, 64'h0, '0);
    wait_resp("t4_resp_cnt2", 2, 50);
    if (resp_q.size() >= 2) chk("t4_line0_kept", resp_q[1], line_t'(8'hA0));
    chk("t4_oob_sticky", line_t'(oob_error), line_t'(1));

    // Reset with reads in flight and responses queued
    repeat (3) tick();
    mem_resp_grant = 1'b0;
    for (int i = 0; i < 7; i++) send(1'b0, 64'(i % 4) << 6, '0);
    tick();
    rstn = 1'b0;
    #1;
    chk("t5_valid_now", line_t'(mem_resp.valid), '0);
    chk("t5_rd_count", line_t'(rd_count), '0);
    chk("t5_wr_count", line_t'(wr_count), '0);
    chk("t5_oob", line_t'(oob_error), '0);
    repeat (2) tick();
    rstn = 1'b1;
    mem_resp_grant = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_resp.valid) cnt++;
      tick();
    end
    chk("t5_no_stale", line_t'(cnt), '0);

    // Alternating write/read pairs with random response backpressure
    resp_q.delete();
    for (int i = 0; i < 16; i++) written[i] = 1'b0;
    rand_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      w = int'($urandom_range(0, 15));
      shadow[w]  = rnd_line();
      written[w] = 1'b1;
      send(1'b1, 64'(w) << 6, shadow[w]);
      r = int'($urandom_range(0, 15));
      if (!written[r]) r = w;
      exp_q.push_back(shadow[r]);
      send(1'b0, 64'(r) << 6, '0);
    end
    rand_en = 1'b0;
    mem_resp_grant = 1'b1;
    wait_resp("t6_resp_cnt", 100, 400);
    if (resp_q.size() >= 100) begin
      for (int i = 0; i < 100; i++) chk("t6_sb_data", resp_q[i], exp_q[i]);
    end
    chk("t6_rd_count", line_t'(rd_count), line_t'(100));
    chk("t6_wr_count", line_t'(wr_count), line_t'(100));
    repeat (10) tick();
    chk("t6_no_dup", line_t'(resp_q.size()), line_t'(100));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
